// File: rtl/chaos_bridge_pkg.sv
// chaos_bridge_pkg: register map, mode codes, FSM states and STATUS bit positions
package chaos_bridge_pkg;
  localparam logic [4:0] A_CTRL = 5'd0, A_BURST = 5'd1, A_STATUS = 5'd2, A_SHIFT = 5'd3;
  localparam logic [4:0] A_TEMP = 5'd4, A_IRQ_EN = 5'd5, A_FIFO = 5'd8;
  typedef enum logic [1:0] {M_IDLE, M_SINGLE, M_BURST, M_FREE} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_RST, S_ISSUE, S_WAIT, S_CAP, S_NEXT} state_e;
  localparam int ST_BUSY = 0, ST_EMPTY = 1, ST_FULL = 2, ST_TMO = 3, ST_LVL = 8;
endpackage

// File: rtl/chaos_sample_fifo.sv
// chaos_sample_fifo: circular sample buffer with wrap-bit pointers and a level count
module chaos_sample_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign level_o = wp_q - rp_q;
  assign empty_o = wp_q == rp_q;
  assign full_o = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
  assign do_pop = pop_i && !empty_o;
  // a pop on a full buffer frees the slot the simultaneous push lands in
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
      if (do_pop) rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/chaos_state_bridge.sv
// chaos_state_bridge: Avalon-MM sequencer for a chaos core; steps it, waits for done and
// buffers each NCH-channel state sample in a FIFO.
module chaos_state_bridge
  import chaos_bridge_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW = 32,
  parameter int TW = 13,
  parameter int FIFO_DEPTH = 16,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              chaos_done,
  input  logic [NCH*DW-1:0] chaos_state,
  input  logic [TW-1:0]     chaos_temp,
  output logic              chaos_reset,
  output logic              chaos_step,
  output logic [DW-1:0]     chaos_shift,
  output logic              irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q;
  mode_e mode_q, wmode;
  logic [15:0] burst_q, bcnt_q;
  logic [DW-1:0] shift_q;
  logic [1:0] irq_en_q;
  logic err_q, done_q, rst_q, step_q, rvalid_q;
  logic [31:0] cnt_q, rdata_q, rdata_d;
  logic [NCH*DW-1:0] head;
  logic [LW-1:0] level;
  logic empty, full, ctrl_wr, abort, start, rise, push, pop;
  assign ctrl_wr = avs_write && avs_address == A_CTRL;
  assign abort = ctrl_wr && avs_writedata[0];
  assign wmode = mode_e'(avs_writedata[3:2]);
  assign start = ctrl_wr && avs_writedata[1] && wmode != M_IDLE && !(wmode == M_BURST && burst_q == '0);
  assign rise = chaos_done && !done_q;
  assign push = state_q == S_CAP;
  assign pop = avs_read && avs_address == 5'(A_FIFO + NCH - 1);
  chaos_sample_fifo #(.W(NCH*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .flush_i(abort), .push_i(push), .data_i(chaos_state),
    .pop_i(pop), .data_o(head), .empty_o(empty), .full_o(full), .level_o(level)
  );
  // cnt_q times both the core-reset hold and the done wait; the two never overlap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= M_IDLE;
      burst_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      irq_en_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      rst_q <= 1'b0;
      step_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      done_q <= chaos_done;
      step_q <= 1'b0;
      if (ctrl_wr) mode_q <= wmode;
      if (ctrl_wr && avs_writedata[4]) err_q <= 1'b0;
      if (avs_write && avs_address == A_BURST) burst_q <= avs_writedata[15:0];
      if (avs_write && avs_address == A_SHIFT) shift_q <= DW'(avs_writedata);
      if (avs_write && avs_address == A_IRQ_EN) irq_en_q <= avs_writedata[1:0];
      if (abort) begin
        state_q <= S_RST;
        rst_q <= 1'b1;
        cnt_q <= '0;
      end else
        case (state_q)
          S_IDLE: if (start) begin
            state_q <= S_ISSUE;
            bcnt_q <= burst_q;
          end
          S_RST: if (cnt_q == RST_CYC - 1) begin
            state_q <= S_IDLE;
            rst_q <= 1'b0;
          end else cnt_q <= cnt_q + 32'd1;
          S_ISSUE: if (!full) begin
            state_q <= S_WAIT;
            step_q <= 1'b1;
            cnt_q <= '0;
          end
          S_WAIT: if (rise) state_q <= S_CAP;
          else if (cnt_q == TIMEOUT - 1) begin
            state_q <= S_IDLE;
            err_q <= 1'b1;
          end else cnt_q <= cnt_q + 32'd1;
          S_CAP: state_q <= S_NEXT;
          S_NEXT: begin
            bcnt_q <= bcnt_q - 16'd1;
            state_q <= (mode_q == M_FREE || (mode_q == M_BURST && bcnt_q > 16'd1)) ? S_ISSUE : S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
    end
  always_comb begin
    rdata_d = '0;
    case (avs_address)
      A_CTRL: rdata_d[3:2] = mode_q;
      A_BURST: rdata_d[15:0] = burst_q;
      A_STATUS: begin
        rdata_d[ST_BUSY] = state_q != S_IDLE;
        rdata_d[ST_EMPTY] = empty;
        rdata_d[ST_FULL] = full;
        rdata_d[ST_TMO] = err_q;
        rdata_d[ST_LVL +: LW] = level;
      end
      A_SHIFT: rdata_d = 32'(shift_q);
      A_TEMP: rdata_d = 32'(chaos_temp);
      A_IRQ_EN: rdata_d[1:0] = irq_en_q;
      default:
        for (int i = 0; i < NCH; i++)
          if (avs_address == 5'(A_FIFO + i) && !empty) rdata_d = 32'(head[i*DW +: DW]);
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q <= avs_read ? rdata_d : '0;
      rvalid_q <= avs_read;
    end
  assign avs_readdata = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign chaos_reset = rst_q;
  assign chaos_step = step_q;
  assign chaos_shift = shift_q;
  assign irq = (irq_en_q[0] && !empty) || (irq_en_q[1] && err_q);
endmodule

// File: tb/tb_chaos_state_bridge.sv
// tb_chaos_state_bridge: directed bench with a behavioural core model and sample scoreboard
module tb_chaos_state_bridge;
  localparam int NCH = 4, DW = 32, TW = 13, DEPTH = 16;
  localparam logic [4:0] CTRL = 5'd0, BURST = 5'd1, STATUS = 5'd2, SHIFT = 5'd3, TEMP = 5'd4, IRQ_EN = 5'd5;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] avs_address = '0;
  logic avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0, avs_readdata;
  logic avs_readdatavalid, chaos_done = 1'b0, chaos_reset, chaos_step, irq;
  logic [NCH*DW-1:0] chaos_state = '0;
  logic [TW-1:0] chaos_temp = 13'h1ABC;
  logic [DW-1:0] chaos_shift;
  int total = 0, bad = 0, steps = 0, rst_len = 0, rst_run = 0, seq = 0, s0;
  logic [31:0] shift_m = '0;
  logic [NCH*DW-1:0] exp_q[$];
  bit core_auto = 1'b1;
  logic step_prev = 1'b0;
  chaos_state_bridge dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .chaos_done(chaos_done), .chaos_state(chaos_state),
    .chaos_temp(chaos_temp), .chaos_reset(chaos_reset), .chaos_step(chaos_step),
    .chaos_shift(chaos_shift), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(posedge clk);
    #1 avs_write = 1'b0;
    if (a == SHIFT) shift_m = d;
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(posedge clk);
    #1 avs_read = 1'b0;
    @(negedge clk);
    d = avs_readdata;
  endtask
  task automatic chk_rd(input string nm, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, e);
  endtask
  task automatic present();
    for (int i = 0; i < NCH; i++) chaos_state[i*DW +: DW] = 32'((seq << 8) | (i + 1));
    exp_q.push_back(chaos_state);
    seq++;
  endtask
  task automatic read_sample(input string nm);
    logic [NCH*DW-1:0] e;
    logic [31:0] d;
    e = exp_q.size() != 0 ? exp_q[0] : '0;
    for (int i = 0; i < NCH; i++) begin
      rd(5'(8 + i), d);
      chk(nm, d, e[i*DW +: DW]);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask
  task automatic wait_idle(input string nm);
    logic [31:0] s;
    int c;
    c = 0;
    do begin rd(STATUS, s); c++; end while (s[0] && c < 300);
    chk(nm, 32'(s[0]), 0);
  endtask
  task automatic wait_steps(input int n, input int lim);
    int c;
    c = 0;
    while (steps < n && c < lim) begin @(posedge clk); c++; end
    chk("wait_steps", 32'(steps >= n), 1);
  endtask
  task automatic drain(input int n, input string nm);
    logic [31:0] s;
    int c;
    for (int k = 0; k < n; k++) begin
      c = 0;
      do begin rd(STATUS, s); c++; end while (s[1] && c < 400);
      chk({nm, "_avail"}, 32'(s[1]), 0);
      read_sample(nm);
    end
  endtask
  // core model: answers each step with the next numbered sample after a fixed latency
  initial forever begin
    @(negedge clk);
    if (chaos_step && core_auto) begin
      repeat (10) @(posedge clk);
      #1;
      if (core_auto) begin
        present();
        chaos_done = 1'b1;
        @(posedge clk);
        #1 chaos_done = 1'b0;
      end
    end
  end
  initial begin
    logic r;
    forever begin
      @(posedge clk);
      r = avs_read;
      @(negedge clk);
      if (!reset) begin
        chk("rvalid", 32'(avs_readdatavalid), 32'(r));
        chk("shift_out", chaos_shift, shift_m);
        chk("step_width", 32'(chaos_step & step_prev), 0);
        if (chaos_step) begin
          steps++;
          chk("step_when_full", 32'(exp_q.size() < DEPTH), 1);
          chk("step_in_rst", 32'(chaos_reset), 0);
        end
        step_prev = chaos_step;
        if (chaos_reset) rst_run++;
        else if (rst_run != 0) begin
          rst_len = rst_run;
          rst_run = 0;
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {28'd0, chaos_reset, chaos_step, irq, avs_readdatavalid}, 0);
    chk("reset_shift", chaos_shift, 0);
    chk("reset_rdata", avs_readdata, 0);
    chk_rd("reset_status", STATUS, 32'h0002);
    chk_rd("temp", TEMP, 32'h1ABC);
    wr(SHIFT, 32'hDEADBEEF);
    chk_rd("shift_rb", SHIFT, 32'hDEADBEEF);
    wr(BURST, 32'h12345);
    chk_rd("burst_rb", BURST, 32'h2345);
    wr(5'd6, 32'hFFFFFFFF);
    chk_rd("unmapped", 5'd6, 0);
    chk_rd("unmapped_hi", 5'd12, 0);
    rst_len = 0;
    wr(CTRL, 32'h1);
    repeat (12) @(posedge clk);
    chk("core_rst_len", rst_len, 4);
    chk_rd("after_rst", STATUS, 32'h0002);
    wr(IRQ_EN, 32'h1);
    chk_rd("irq_en_rb", IRQ_EN, 32'h1);
    s0 = steps;
    wr(CTRL, 32'h6);
    wait_idle("single_idle");
    chk("single_steps", steps - s0, 1);
    chk("irq_nonempty", 32'(irq), 1);
    chk_rd("ch0", 5'd8, 1);
    chk_rd("ch1", 5'd9, 2);
    chk_rd("ch2", 5'd10, 3);
    chk_rd("ch3", 5'd11, 4);
    void'(exp_q.pop_front());
    chk_rd("single_empty", STATUS, 32'h0002);
    chk("irq_drained", 32'(irq), 0);
    chk_rd("empty_read", 5'd8, 0);
    core_auto = 1'b0;
    chaos_done = 1'b1;
    wr(CTRL, 32'h6);
    repeat (20) @(posedge clk);
    chk_rd("done_high_wait", STATUS, 32'h0003);
    present();
    chaos_done = 1'b0;
    @(posedge clk);
    #1 chaos_done = 1'b1;
    @(posedge clk);
    #1 chaos_done = 1'b0;
    wait_idle("late_done_idle");
    read_sample("late_done");
    core_auto = 1'b1;
    wr(BURST, 0);
    s0 = steps;
    wr(CTRL, 32'hA);
    repeat (20) @(posedge clk);
    chk("burst0_steps", steps - s0, 0);
    chk_rd("burst0_status", STATUS, 32'h0002);
    wr(BURST, 20);
    s0 = steps;
    wr(CTRL, 32'hA);
    wait_steps(s0 + 16, 1000);
    repeat (60) @(posedge clk);
    chk("burst_stall_steps", steps - s0, 16);
    chk_rd("burst_full", STATUS, 32'h1005);
    read_sample("burst_pop");
    wait_steps(s0 + 17, 100);
    chk("burst_resume", steps - s0, 17);
    drain(19, "burst");
    wait_idle("burst_idle");
    chk("burst_total", steps - s0, 20);
    chk_rd("burst_done", STATUS, 32'h0002);
    s0 = steps;
    wr(CTRL, 32'hE);
    wait_steps(s0 + 1, 100);
    repeat (3) @(posedge clk);
    wr(CTRL, 32'h0);
    repeat (40) @(posedge clk);
    chk("free_steps", steps - s0, 1);
    chk_rd("free_status", STATUS, 32'h0100);
    read_sample("free");
    chk_rd("free_empty", STATUS, 32'h0002);
    wr(BURST, 20);
    s0 = steps;
    wr(CTRL, 32'hA);
    wait_steps(s0 + 6, 400);
    repeat (3) @(posedge clk);
    chk_rd("abort_before", STATUS, 32'h0501);
    core_auto = 1'b0;
    rst_len = 0;
    wr(CTRL, 32'h1);
    exp_q.delete();
    repeat (10) @(posedge clk);
    chk("abort_rst_len", rst_len, 4);
    chk_rd("abort_after", STATUS, 32'h0002);
    chk("abort_steps", steps - s0, 6);
    chk("abort_irq", 32'(irq), 0);
    wr(IRQ_EN, 32'h2);
    wr(CTRL, 32'h6);
    repeat (65500) @(posedge clk);
    chk_rd("tmo_before", STATUS, 32'h0003);
    chk("tmo_irq_before", 32'(irq), 0);
    repeat (60) @(posedge clk);
    chk_rd("tmo_after", STATUS, 32'h000A);
    chk("tmo_irq", 32'(irq), 1);
    wr(CTRL, 32'h10);
    @(negedge clk);
    chk("tmo_irq_clr", 32'(irq), 0);
    chk_rd("tmo_cleared", STATUS, 32'h0002);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
